// File: rtl/sys_defs.sv
// Shared rename types: map table entry, checkpoint ID and default sizes.
package sys_defs;

    localparam int NUM_ARCH_REGS = 64;
    localparam int NUM_PHYS_REGS = 128;
    localparam int NUM_WB_PORTS  = 4;
    localparam int CKPT_DEPTH    = 4;
    localparam int PHYS_TAG_W    = $clog2(NUM_PHYS_REGS);
    localparam int CKPT_ID_W     = $clog2(CKPT_DEPTH);

    typedef logic [PHYS_TAG_W-1:0] phys_tag_t;
    typedef logic [CKPT_ID_W-1:0]  ckpt_id_t;

    typedef struct packed {
        phys_tag_t phys;
        logic      valid;
    } map_entry_t;

endpackage

// File: rtl/map_checkpoint_stack_slot.sv
// One checkpoint slot: snapshot register, live/captured bits.
// MAP_CKPT_WB_UPDATE_EN: live snapshots pick up writeback ready bits.
module map_ckpt_slot
    import sys_defs::*;
#(
    parameter int ARCH_REGS = NUM_ARCH_REGS,
    parameter int PHYS_REGS = NUM_PHYS_REGS,
    parameter int WB_WIDTH  = NUM_WB_PORTS
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       clear,
    input  logic                                       set_live,
    input  logic                                       kill,
    input  logic                                       capture,
    input  map_entry_t [ARCH_REGS-1:0]                 cap_data,
    input  logic [WB_WIDTH-1:0]                        wb_valid,
    input  logic [WB_WIDTH-1:0][$clog2(PHYS_REGS)-1:0] wb_phys,
    output logic                                       live,
    output logic                                       captured,
    output map_entry_t [ARCH_REGS-1:0]                 snap_next
);

    map_entry_t [ARCH_REGS-1:0] snapshot;
    map_entry_t [ARCH_REGS-1:0] base;

    always_comb begin
        base      = capture ? cap_data : snapshot;
        snap_next = base;
`ifdef MAP_CKPT_WB_UPDATE_EN
        if (live) begin
            for (int j = 0; j < ARCH_REGS; j++) begin
                for (int i = 0; i < WB_WIDTH; i++) begin
                    if (wb_valid[i] && base[j].phys == wb_phys[i])
                        snap_next[j].valid = 1'b1;
                end
            end
        end
`endif
    end

`ifndef MAP_CKPT_WB_UPDATE_EN
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_phys};
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            live     <= 1'b0;
            captured <= 1'b0;
            snapshot <= '0;
        end else if (clear) begin
            live     <= 1'b0;
            captured <= 1'b0;
        end else begin
            if (set_live) begin
                live     <= 1'b1;
                captured <= 1'b0;
            end else if (kill) begin
                live <= 1'b0;
            end
            if (capture)
                captured <= 1'b1;
            snapshot <= snap_next;
        end
    end

endmodule

// File: rtl/map_checkpoint_stack.sv
// Branch checkpoint stack: allocate, capture, retire, restore on mispredict.
// MAP_CKPT_WB_UPDATE_EN enables writeback updates inside map_ckpt_slot.
module map_checkpoint_stack
    import sys_defs::*;
#(
    parameter int ARCH_REGS = NUM_ARCH_REGS,
    parameter int PHYS_REGS = NUM_PHYS_REGS,
    parameter int DEPTH     = CKPT_DEPTH,
    parameter int WB_WIDTH  = NUM_WB_PORTS
) (
    input  logic                                       clock,
    input  logic                                       reset,
    input  logic                                       alloc_i,
    output logic [$clog2(DEPTH)-1:0]                   alloc_id_o,
    output logic                                       full_o,
    output logic [$clog2(DEPTH):0]                     count_o,
    input  logic                                       ckpt_valid_i,
    input  map_entry_t [ARCH_REGS-1:0]                 ckpt_data_i,
    input  logic                                       br_resolve_valid_i,
    input  logic                                       br_mispredict_i,
    input  logic [$clog2(DEPTH)-1:0]                   br_id_i,
    input  logic                                       flush_i,
    output logic                                       restore_valid_o,
    output map_entry_t [ARCH_REGS-1:0]                 restore_data_o,
    input  logic [WB_WIDTH-1:0]                        wb_valid_i,
    input  logic [WB_WIDTH-1:0][$clog2(PHYS_REGS)-1:0] wb_phys_i
);

    localparam int IDW = $clog2(DEPTH);
    typedef logic [IDW-1:0] id_t;
    typedef logic [IDW:0]   cnt_t;

    id_t  head, tail, pend_id, mp_age;
    cnt_t count, retire;
    logic pend_valid, stop;
    logic mispredict, resolve_ok, do_alloc, do_capture;

    logic [DEPTH-1:0] live, captured, clr, set_live, kill, cap, live_after;
    id_t age [DEPTH];
    map_entry_t [ARCH_REGS-1:0] snap_next [DEPTH];

    assign full_o     = (count == cnt_t'(DEPTH));
    assign alloc_id_o = tail;
    assign count_o    = count;

    // A mispredict squashes the younger path, so it outranks alloc/capture.
    assign mispredict = br_resolve_valid_i && br_mispredict_i
                        && live[br_id_i] && captured[br_id_i];
    assign resolve_ok = br_resolve_valid_i && !br_mispredict_i
                        && live[br_id_i];
    assign do_alloc   = alloc_i && !full_o && !mispredict && !flush_i;
    assign do_capture = ckpt_valid_i && pend_valid && live[pend_id]
                        && !mispredict && !flush_i;
    assign mp_age     = br_id_i - head;

    always_comb begin
        clr        = '0;
        set_live   = '0;
        kill       = '0;
        cap        = '0;
        live_after = '0;
        retire     = '0;
        stop       = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            age[k]        = id_t'(k) - head;
            clr[k]        = flush_i || (mispredict
                            && cnt_t'(age[k]) >= cnt_t'(mp_age)
                            && cnt_t'(age[k]) < count);
            set_live[k]   = do_alloc && (tail == id_t'(k));
            kill[k]       = resolve_ok && (br_id_i == id_t'(k));
            cap[k]        = do_capture && (pend_id == id_t'(k));
            live_after[k] = live[k] && !kill[k];
        end
        // Retire the run of dead slots starting at head.
        for (int i = 0; i < DEPTH; i++) begin
            if (!stop && cnt_t'(i) < count
                && !live_after[id_t'(head + id_t'(i))])
                retire = retire + cnt_t'(1);
            else
                stop = 1'b1;
        end
    end

    for (genvar k = 0; k < DEPTH; k++) begin : g_slot
        map_ckpt_slot #(
            .ARCH_REGS (ARCH_REGS),
            .PHYS_REGS (PHYS_REGS),
            .WB_WIDTH  (WB_WIDTH)
        ) u_slot (
            .clock     (clock),
            .reset     (reset),
            .clear     (clr[k]),
            .set_live  (set_live[k]),
            .kill      (kill[k]),
            .capture   (cap[k]),
            .cap_data  (ckpt_data_i),
            .wb_valid  (wb_valid_i),
            .wb_phys   (wb_phys_i),
            .live      (live[k]),
            .captured  (captured[k]),
            .snap_next (snap_next[k])
        );
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            pend_valid      <= 1'b0;
            pend_id         <= '0;
            restore_valid_o <= 1'b0;
            restore_data_o  <= '0;
        end else if (flush_i) begin
            head            <= '0;
            tail            <= '0;
            count           <= '0;
            pend_valid      <= 1'b0;
            restore_valid_o <= 1'b0;
        end else if (mispredict) begin
            tail            <= br_id_i;
            count           <= cnt_t'(mp_age);
            pend_valid      <= 1'b0;
            restore_valid_o <= 1'b1;
            restore_data_o  <= snap_next[br_id_i];
        end else begin
            restore_valid_o <= 1'b0;
            head            <= head + id_t'(retire);
            count           <= count - retire + cnt_t'(do_alloc);
            if (do_alloc) begin
                tail       <= tail + id_t'(1);
                pend_valid <= 1'b1;
                pend_id    <= tail;
            end else if (do_capture) begin
                pend_valid <= 1'b0;
            end
        end
    end

    a_no_alloc_full: assert property (@(posedge clock) disable iff (!reset)
        !(alloc_i && full_o && !flush_i));

    a_mp_valid_slot: assert property (@(posedge clock) disable iff (!reset)
        !(br_resolve_valid_i && br_mispredict_i && !flush_i)
        || (live[br_id_i] && captured[br_id_i]));

endmodule

// File: tb/tb_map_checkpoint_stack.sv
// Scoreboard bench for map_checkpoint_stack (DEPTH=4, ARCH_REGS=64).
module tb_map_checkpoint_stack;
    import sys_defs::*;

    localparam int DEPTH = 4;
    localparam int ARCH  = 64;
    localparam int WB    = 4;
    localparam int PW    = $clog2(128);

    typedef map_entry_t [ARCH-1:0] snap_t;

    typedef struct {
        string      name;
        logic [2:0] cnt;
        logic       full;
        logic [1:0] id;
    } stat_t;

    typedef struct {
        string name;
        snap_t data;
    } rest_t;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   alloc_i;
    logic [1:0]             alloc_id_o;
    logic                   full_o;
    logic [2:0]             count_o;
    logic                   ckpt_valid_i;
    snap_t                  ckpt_data_i;
    logic                   br_resolve_valid_i;
    logic                   br_mispredict_i;
    logic [1:0]             br_id_i;
    logic                   flush_i;
    logic                   restore_valid_o;
    snap_t                  restore_data_o;
    logic [WB-1:0]          wb_valid_i;
    logic [WB-1:0][PW-1:0]  wb_phys_i;

    int    checks = 0;
    int    errors = 0;
    stat_t stat_q[$];
    rest_t rest_q[$];
    stat_t m_s;
    rest_t m_r;
    snap_t snaps [DEPTH];
    snap_t s_extra, s_wb, s_wb_exp, junk;

    map_checkpoint_stack #(
        .ARCH_REGS (ARCH),
        .PHYS_REGS (128),
        .DEPTH     (DEPTH),
        .WB_WIDTH  (WB)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .alloc_i            (alloc_i),
        .alloc_id_o         (alloc_id_o),
        .full_o             (full_o),
        .count_o            (count_o),
        .ckpt_valid_i       (ckpt_valid_i),
        .ckpt_data_i        (ckpt_data_i),
        .br_resolve_valid_i (br_resolve_valid_i),
        .br_mispredict_i    (br_mispredict_i),
        .br_id_i            (br_id_i),
        .flush_i            (flush_i),
        .restore_valid_o    (restore_valid_o),
        .restore_data_o     (restore_data_o),
        .wb_valid_i         (wb_valid_i),
        .wb_phys_i          (wb_phys_i)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [511:0] act,
                       input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic snap_t make_snap(input int seed, input int inv);
        snap_t s;
        for (int j = 0; j < ARCH; j++) begin
            s[j].phys  = phys_tag_t'((j + seed) % 128);
            s[j].valid = (j != inv);
        end
        return s;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        alloc_i            = 1'b0;
        ckpt_valid_i       = 1'b0;
        br_resolve_valid_i = 1'b0;
        br_mispredict_i    = 1'b0;
        flush_i            = 1'b0;
        wb_valid_i         = '0;
    endtask

    task automatic expect_stat(input string n, input int c, input bit f,
                               input int id);
        stat_q.push_back('{name: n, cnt: 3'(c), full: f, id: 2'(id)});
    endtask

    task automatic mispredict(input int id, input bit exp_pulse,
                              input snap_t exp_data, input string n);
        br_resolve_valid_i = 1'b1;
        br_mispredict_i    = 1'b1;
        br_id_i            = 2'(id);
        if (exp_pulse)
            rest_q.push_back('{name: n, data: exp_data});
    endtask

    // Monitor: status checks queued by stimulus, restores on each pulse.
    always @(negedge clock) begin
        if (stat_q.size() != 0) begin
            m_s = stat_q.pop_front();
            chk({m_s.name, "_count"}, 512'(count_o), 512'(m_s.cnt));
            chk({m_s.name, "_full"}, 512'(full_o), 512'(m_s.full));
            chk({m_s.name, "_id"}, 512'(alloc_id_o), 512'(m_s.id));
        end
        if (restore_valid_o) begin
            if (rest_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_restore: got pulse expected none");
            end else begin
                m_r = rest_q.pop_front();
                chk(m_r.name, restore_data_o, m_r.data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < DEPTH; k++)
            snaps[k] = make_snap(64 + k, -1);
        s_extra = make_snap(90, -1);
        junk    = make_snap(7, 3);
        s_wb    = make_snap(65, 5);
        idle();
        br_id_i     = '0;
        ckpt_data_i = '0;
        wb_phys_i   = '0;
        reset       = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        chk("reset_rv", 512'(restore_valid_o), 512'(0));
        chk("reset_rd", restore_data_o, 512'(0));
        expect_stat("reset", 0, 0, 0);
        tick();

        // Fill all four slots, capturing each on the following cycle.
        for (int i = 0; i < DEPTH; i++) begin
            alloc_i = 1'b1;
            if (i > 0) begin
                ckpt_valid_i = 1'b1;
                ckpt_data_i  = snaps[i-1];
            end
            expect_stat($sformatf("alloc%0d", i), i, 0, i);
            tick();
        end
        alloc_i     = 1'b0;
        ckpt_data_i = snaps[3];
        expect_stat("fill", 4, 1, 0);
        tick();

        idle();
        mispredict(1, 1, snaps[1], "mp1_data");
        expect_stat("full", 4, 1, 0);
        tick();
        idle();
        chk("mp1_e5_phys", 512'(restore_data_o[5].phys), 512'(70));
        expect_stat("mp1_after", 1, 0, 1);
        tick();

        // Out-of-order correct resolves.
        alloc_i = 1'b1;
        expect_stat("re_a1", 1, 0, 1);
        tick();
        ckpt_valid_i = 1'b1;
        ckpt_data_i  = snaps[1];
        expect_stat("re_a2", 2, 0, 2);
        tick();
        alloc_i     = 1'b0;
        ckpt_data_i = snaps[2];
        expect_stat("re_cap", 3, 0, 3);
        tick();
        idle();
        br_resolve_valid_i = 1'b1;
        br_id_i            = 2'd1;
        expect_stat("res_pre", 3, 0, 3);
        tick();
        br_id_i = 2'd0;
        expect_stat("res1", 3, 0, 3);
        tick();
        idle();
        expect_stat("res0", 1, 0, 3);
        tick();

        // Mispredict beats same-cycle alloc and capture.
        alloc_i = 1'b1;
        expect_stat("ma_a3", 1, 0, 3);
        tick();
        ckpt_valid_i = 1'b1;
        ckpt_data_i  = junk;
        mispredict(2, 1, snaps[2], "mp2_data");
        expect_stat("ma_pre", 2, 0, 0);
        tick();
        idle();
        expect_stat("mp_alloc", 0, 0, 2);
        tick();
        alloc_i = 1'b1;
        expect_stat("ma_re", 0, 0, 2);
        tick();
        idle();
        ckpt_valid_i = 1'b1;
        ckpt_data_i  = s_extra;
        expect_stat("ma_cap", 1, 0, 3);
        tick();
        idle();
        mispredict(2, 1, s_extra, "mp2b_data");
        expect_stat("ma_mp", 1, 0, 3);
        tick();
        idle();
        expect_stat("ma_end", 0, 0, 2);
        tick();

        // Flush beats a same-cycle mispredict and alloc.
        alloc_i = 1'b1;
        expect_stat("fl_a2", 0, 0, 2);
        tick();
        ckpt_valid_i = 1'b1;
        ckpt_data_i  = snaps[0];
        expect_stat("fl_a3", 1, 0, 3);
        tick();
        idle();
        flush_i = 1'b1;
        alloc_i = 1'b1;
        mispredict(2, 0, '0, "");
        expect_stat("fl_pre", 2, 0, 0);
        tick();
        idle();
        chk("flush_rd_hold", restore_data_o, s_extra);
        expect_stat("flush", 0, 0, 0);
        tick();

        // Writeback between capture and restore.
        alloc_i = 1'b1;
        expect_stat("wb_a0", 0, 0, 0);
        tick();
        idle();
        ckpt_valid_i = 1'b1;
        ckpt_data_i  = s_wb;
        expect_stat("wb_cap", 1, 0, 1);
        tick();
        idle();
        wb_valid_i   = 4'b0100;
        wb_phys_i[2] = PW'(70);
        wb_phys_i[0] = PW'(70);
        expect_stat("wb_wb", 1, 0, 1);
        tick();
        idle();
        s_wb_exp = s_wb;
`ifdef MAP_CKPT_WB_UPDATE_EN
        s_wb_exp[5].valid = 1'b1;
`endif
        mispredict(0, 1, s_wb_exp, "wb_data");
        expect_stat("wb_mp", 1, 0, 1);
        tick();
        idle();
`ifdef MAP_CKPT_WB_UPDATE_EN
        chk("wb_e5_valid", 512'(restore_data_o[5].valid), 512'(1));
`else
        chk("wb_e5_valid", 512'(restore_data_o[5].valid), 512'(0));
`endif
        expect_stat("wb_end", 0, 0, 0);
        tick();

        // Asynchronous reset with three live slots.
        for (int i = 0; i < 3; i++) begin
            alloc_i = 1'b1;
            if (i > 0) begin
                ckpt_valid_i = 1'b1;
                ckpt_data_i  = snaps[i];
            end
            expect_stat($sformatf("rs_a%0d", i), i, 0, i);
            tick();
        end
        idle();
        expect_stat("rs_live", 3, 0, 3);
        tick();
        #2;
        reset = 1'b0;
        #1;
        chk("arst_count", 512'(count_o), 512'(0));
        chk("arst_full", 512'(full_o), 512'(0));
        chk("arst_id", 512'(alloc_id_o), 512'(0));
        chk("arst_rv", 512'(restore_valid_o), 512'(0));
        chk("arst_rd", restore_data_o, 512'(0));
        tick();
        reset = 1'b1;
        alloc_i = 1'b1;
        expect_stat("rs_restart", 0, 0, 0);
        tick();
        idle();
        expect_stat("rs_after", 1, 0, 1);
        tick();
        tick();
        chk("restores_seen", 512'(rest_q.size()), 512'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/map_checkpoint_stack.md
Name: map_checkpoint_stack

Overview:
- Branch checkpoint store on the other end of the map table's snapshot interface.
- Allocates a checkpoint ID when a branch dispatches.
- Captures the map table snapshot on the following cycle's checkpoint-valid pulse.
- Frees checkpoints as branches resolve correctly. On a mispredict, returns the saved mapping as a one-cycle restore pulse and squashes that checkpoint and all younger ones.

Parameters:
- ARCH_REGS, 64: architectural registers per snapshot.
- PHYS_REGS, 128: physical registers; sets the phys tag width.
- DEPTH, 4: checkpoint slots; power of two, at least 2.
- WB_WIDTH, 4: writeback ports; used only with the optional feature.

Ports:
- clock  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- alloc_i  in  1  branch dispatched this cycle; request a checkpoint ID.
- alloc_id_o  out  $clog2(DEPTH)  ID given to the branch dispatching this cycle; equals the tail pointer.
- full_o  out  1  no free slot; dispatch stalls branches.
- count_o  out  $clog2(DEPTH)+1  number of live checkpoints.
- ckpt_valid_i  in  1  the map table's checkpoint-valid pulse.
- ckpt_data_i  in  map_entry_t[ARCH_REGS]  the map table's snapshot output.
- br_resolve_valid_i  in  1  a branch resolved.
- br_mispredict_i  in  1  the resolved branch mispredicted.
- br_id_i  in  $clog2(DEPTH)  checkpoint ID of the resolved branch.
- flush_i  in  1  discard all checkpoints.
- restore_valid_o  out  1  drives the map table's snapshot-restore valid input.
- restore_data_o  out  map_entry_t[ARCH_REGS]  drives the map table's snapshot-data input.
- wb_valid_i  in  WB_WIDTH  writeback valids; used only with the optional feature.
- wb_phys_i  in  WB_WIDTH x $clog2(PHYS_REGS)  writeback tags; used only with the optional feature.

Behaviour:

State:
- Circular buffer: head (oldest live), tail (next to allocate), count.
- Per slot: live bit, captured bit, snapshot.
- pend_valid/pend_id register: slot awaiting capture.

Reset (reset low, asynchronous):
- head=tail=count=0; all live/captured bits 0; pend_valid=0.
- restore_valid_o=0; restore_data_o all zero.
- Hence full_o=0, alloc_id_o=0, count_o=0.
- Release of reset mid-operation: state restarts empty.

Allocation:
- alloc_i && !full_o: set slot[tail].live, tail+1 mod DEPTH, count+1, pend_valid<=1, pend_id<=tail.
- alloc_i while full_o: ignored. Caller must not do this; assertion in simulation.

Capture:
- ckpt_valid_i && pend_valid && slot[pend_id].live: slot[pend_id].snapshot<=ckpt_data_i, captured<=1, pend_valid<=0 unless re-set by same-cycle alloc.
- ckpt_valid_i with no pending slot: ignored.

Correct resolve (br_resolve_valid_i && !br_mispredict_i, slot live):
- Clear live.
- Head advances past every non-live slot from head up to tail; count drops by slots retired.
- Out-of-order correct resolves are allowed. Slots resolved ahead of head stay dead but are counted until head passes them.

Mispredict (resolve && br_mispredict_i, slot[br_id_i].live && captured):
- Next cycle: restore_valid_o=1 for exactly one cycle; restore_data_o=slot[br_id_i].snapshot.
- Same edge: slots br_id_i..tail-1 cleared; tail<=br_id_i; count recomputed as (br_id_i-head) mod DEPTH; pend_valid<=0.
- restore_data_o holds its value until the next restore.

Simultaneous events:
- Mispredict beats alloc and capture in the same cycle; both are dropped, since they belong to the squashed younger path.
- Mispredict on a non-live slot or an uncaptured slot: ignored, no pulse. Assertion in simulation.
- flush_i beats everything: empty state as at reset, restore_valid_o=0, restore_data_o unchanged.

Wrap-around:
- All pointers are mod DEPTH.
- full_o = (count==DEPTH).

Optional Feature:
- Macro: MAP_CKPT_WB_UPDATE_EN.
- Defined: each cycle, for every live slot, entry j and every wb port i with wb_valid_i[i] and snapshot[j].phys==wb_phys_i[i], set snapshot[j].valid<=1.
- Defined, capture-cycle writeback: a writeback in the capture cycle applies to the captured data.
- Defined, restore output: restore_data_o carries up-to-date valid bits.
- Undefined: wb ports are unused, and valid bits stay exactly as captured.

Decomposition:
- map_entry_t {phys, valid} lives in the shared sys_defs package.
- Also in the package: CKPT_DEPTH and the ckpt_id_t typedef.
- One natural sub-module: map_ckpt_slot (one snapshot register plus live/captured bits plus the optional wb update), instantiated DEPTH times.
- Pointer and count logic stays in the top module.

Test Plan:
- Reset low mid-run with 3 live slots -> count_o=0, full_o=0, alloc_id_o=0, restore_valid_o=0 immediately, without waiting for a clock edge.
- Four allocs, each with a capture on the next cycle, DEPTH=4 -> IDs 0,1,2,3; full_o=1; a fifth alloc is ignored and tail stays at 0.
- Slot 1 captured with arch 5->phys 70; mispredict br_id_i=1 -> next cycle restore_valid_o=1 for one cycle with entry 5 phys=70; tail=1; count_o=1.
- Resolve ID 1 correct, then ID 0 correct -> count stays 3 after the first, then drops to 1 once head passes slots 0 and 1.
- Mispredict and alloc in the same cycle -> alloc dropped, alloc_id_o=br_id_i, pending capture cancelled.
- With MAP_CKPT_WB_UPDATE_EN: slot 0 has phys 70 invalid; wb phys 70; mispredict ID 0 -> restored entry valid=1. Without the macro -> valid=0.
